// File: rtl/core_pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: hold levels, FSM states and
// the hold-flag bus width used by the PC/IF/ID registers.
package core_pipe_ctrl_pkg;

  localparam int HOLD_FLAG_BUS_W = 3;
  localparam int DRAIN_CNT_W     = 3;

  typedef logic [HOLD_FLAG_BUS_W-1:0] hold_t;

  // A stage freezes when the hold level is >= its own level.
  localparam hold_t HOLD_NONE = 3'd0;
  localparam hold_t HOLD_PC   = 3'd1;
  localparam hold_t HOLD_IF   = 3'd2;
  localparam hold_t HOLD_ID   = 3'd3;

  // Legacy name still referenced by the PC register.
  localparam hold_t HoldPc = HOLD_PC;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  function automatic logic [DRAIN_CNT_W-1:0] drain_init(input int cycles);
    return DRAIN_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/core_pipe_ctrl.sv
// Pipeline controller: merges execute jumps and stalls into the PC/IF/ID
// redirect and hold controls, and sequences interrupt entry and debug halt.
module core_pipe_ctrl #(
  parameter int                ADDR_W       = 32,
  parameter int                HOLD_W       = 3,
  parameter int                DRAIN_CYCLES = 2,
  parameter logic [ADDR_W-1:0] RST_ADDR     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              ex_jump_flag_in,
  input  logic [ADDR_W-1:0] ex_jump_addr_in,
  input  logic              ex_hold_req_in,
  input  logic              bus_hold_req_in,
  input  logic              int_req_in,
  input  logic [ADDR_W-1:0] int_addr_in,
  input  logic              dbg_halt_req_in,
  output logic              jump_flag_out,
  output logic [ADDR_W-1:0] jump_addr_out,
  output logic [HOLD_W-1:0] hold_flag_out,
  output logic              int_ack_out,
  output logic [ADDR_W-1:0] epc_out,
  output logic              halted_out
);

  import core_pipe_ctrl_pkg::*;

  state_e                  state_reg, state_next;
  logic [DRAIN_CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0]       int_addr_reg, int_addr_next;
  logic [ADDR_W-1:0]       epc_reg, epc_next;
  hold_t                   hold_lvl;
  logic                    any_stall;

  // An interrupt is only accepted on a quiet cycle; otherwise it stays pending.
  assign any_stall = ex_jump_flag_in | ex_hold_req_in | bus_hold_req_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      cnt_reg      <= '0;
      int_addr_reg <= '0;
      epc_reg      <= RST_ADDR;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      int_addr_reg <= int_addr_next;
      epc_reg      <= epc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    int_addr_next = int_addr_reg;
    epc_next      = epc_reg;
    case (state_reg)
      ST_RUN: begin
        if (int_req_in && !any_stall) begin
          state_next    = ST_DRAIN;
          int_addr_next = int_addr_in;
          epc_next      = pc_in;
          cnt_next      = drain_init(DRAIN_CYCLES);
        end else if (dbg_halt_req_in) begin
          state_next = ST_HALT;
        end
      end
      ST_DRAIN: begin
        // A branch retiring during drain redefines where to resume.
        if (ex_jump_flag_in) begin
          epc_next = ex_jump_addr_in;
        end
        if (!bus_hold_req_in) begin
          if (cnt_reg == '0) begin
            state_next = ST_TRAP;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      ST_TRAP: begin
        state_next = ST_RUN;
      end
      ST_HALT: begin
        if (!dbg_halt_req_in) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_comb begin
    jump_flag_out = 1'b0;
    jump_addr_out = '0;
    int_ack_out   = 1'b0;
    halted_out    = 1'b0;
    hold_lvl      = HOLD_NONE;
    if (!rst) begin
      case (state_reg)
        ST_RUN: begin
          jump_flag_out = ex_jump_flag_in;
          jump_addr_out = ex_jump_flag_in ? ex_jump_addr_in : '0;
          if (ex_jump_flag_in || ex_hold_req_in) begin
            hold_lvl = HOLD_ID;
          end else if (bus_hold_req_in) begin
            hold_lvl = HOLD_PC;
          end
        end
        ST_DRAIN: begin
          hold_lvl = HOLD_PC;
        end
        ST_TRAP: begin
          jump_flag_out = 1'b1;
          jump_addr_out = int_addr_reg;
          hold_lvl      = HOLD_ID;
          int_ack_out   = 1'b1;
        end
        ST_HALT: begin
          hold_lvl   = HOLD_ID;
          halted_out = 1'b1;
        end
        default: begin
          hold_lvl = HOLD_NONE;
        end
      endcase
    end
  end

  assign hold_flag_out = HOLD_W'(hold_lvl);
  assign epc_out       = epc_reg;

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Directed testbench for core_pipe_ctrl: each task drives one scenario cycle
// by cycle and compares the combinational control outputs and epc_out.
module tb_core_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        ex_jump_flag_in;
  logic [31:0] ex_jump_addr_in;
  logic        ex_hold_req_in;
  logic        bus_hold_req_in;
  logic        int_req_in;
  logic [31:0] int_addr_in;
  logic        dbg_halt_req_in;
  logic        jump_flag_out;
  logic [31:0] jump_addr_out;
  logic [2:0]  hold_flag_out;
  logic        int_ack_out;
  logic [31:0] epc_out;
  logic        halted_out;

  int checks = 0;
  int errors = 0;

  // {jump_flag, jump_addr, hold_flag, int_ack, halted}
  logic [37:0] obs;
  logic [37:0] e;
  assign obs = {jump_flag_out, jump_addr_out, hold_flag_out, int_ack_out, halted_out};

  core_pipe_ctrl #(
    .ADDR_W(32), .HOLD_W(3), .DRAIN_CYCLES(2), .RST_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in),
    .ex_jump_flag_in(ex_jump_flag_in), .ex_jump_addr_in(ex_jump_addr_in),
    .ex_hold_req_in(ex_hold_req_in), .bus_hold_req_in(bus_hold_req_in),
    .int_req_in(int_req_in), .int_addr_in(int_addr_in),
    .dbg_halt_req_in(dbg_halt_req_in),
    .jump_flag_out(jump_flag_out), .jump_addr_out(jump_addr_out),
    .hold_flag_out(hold_flag_out), .int_ack_out(int_ack_out),
    .epc_out(epc_out), .halted_out(halted_out)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] ev(input logic jf, input logic [31:0] ja,
                                     input logic [2:0] hf, input logic ack,
                                     input logic h);
    return {jf, ja, hf, ack, h};
  endfunction

  // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    ex_jump_flag_in = 1'b0;
    ex_jump_addr_in = 32'h0;
    ex_hold_req_in  = 1'b0;
    bus_hold_req_in = 1'b0;
    int_req_in      = 1'b0;
    int_addr_in     = 32'h0;
    dbg_halt_req_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_jump_flag_in = 1'b1; ex_jump_addr_in = 32'h55;
    int_req_in = 1'b1; dbg_halt_req_in = 1'b1; bus_hold_req_in = 1'b1;
    tick();
    settle();
    e = ev(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs, e); end
    else $display("ok   reset_outputs: %h", obs);
    tick();
    rst = 1'b0;
    clear_inputs();
    settle();
    e = ev(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_run_idle: got %h expected %h", obs, e); end
    else $display("ok   reset_run_idle: %h", obs);
    checks++;
    if (epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected %h", epc_out, 32'h0); end
    else $display("ok   reset_epc: %h", epc_out);
    tick();
  endtask

  task automatic test_jump();
    ex_jump_flag_in = 1'b1; ex_jump_addr_in = 32'h100;
    settle();
    e = ev(1, 32'h100, 3, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL jump_pass: got %h expected %h", obs, e); end
    else $display("ok   jump_pass: %h", obs);
    tick();
    clear_inputs();
    ex_jump_addr_in = 32'h104;
    settle();
    e = ev(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL jump_after: got %h expected %h", obs, e); end
    else $display("ok   jump_after: %h", obs);
    tick();
  endtask

  task automatic test_holds();
    logic [2:0] pat [4];
    logic [2:0] want [4];
    // {ex_hold, bus_hold, unused}
    pat[0] = 3'b100; want[0] = 3'd3;
    pat[1] = 3'b010; want[1] = 3'd1;
    pat[2] = 3'b110; want[2] = 3'd3;
    pat[3] = 3'b000; want[3] = 3'd0;
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      ex_hold_req_in  = pat[i][2];
      bus_hold_req_in = pat[i][1];
      int_req_in      = 1'b0;
      settle();
      e = ev(0, 0, want[i], 0, 0); checks++;
      if (obs !== e) begin errors++; $display("FAIL hold_merge_%0d: got %h expected %h", i, obs, e); end
      else $display("ok   hold_merge_%0d: %h", i, obs);
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_int_entry();
    pc_in = 32'h40; int_req_in = 1'b1; int_addr_in = 32'h80;
    settle();
    e = ev(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL int_accept: got %h expected %h", obs, e); end
    else $display("ok   int_accept: %h", obs);
    tick();
    // Vector and PC change after entry; the captured values must not follow.
    int_addr_in = 32'hDEAD; pc_in = 32'h44;
    for (int i = 0; i < 2; i++) begin
      settle();
      e = ev(0, 0, 1, 0, 0); checks++;
      if (obs !== e) begin errors++; $display("FAIL int_drain_%0d: got %h expected %h", i, obs, e); end
      else $display("ok   int_drain_%0d: %h", i, obs);
      tick();
    end
    settle();
    e = ev(1, 32'h80, 3, 1, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL int_trap: got %h expected %h", obs, e); end
    else $display("ok   int_trap: %h", obs);
    checks++;
    if (epc_out !== 32'h40) begin errors++; $display("FAIL int_epc: got %h expected %h", epc_out, 32'h40); end
    else $display("ok   int_epc: %h", epc_out);
    tick();
    clear_inputs();
    settle();
    e = ev(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL int_return_run: got %h expected %h", obs, e); end
    else $display("ok   int_return_run: %h", obs);
    tick();
  endtask

  task automatic test_deferral();
    pc_in = 32'h50; int_req_in = 1'b1; int_addr_in = 32'h300;
    ex_jump_flag_in = 1'b1; ex_jump_addr_in = 32'h120;
    settle();
    e = ev(1, 32'h120, 3, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL defer_jump_fwd: got %h expected %h", obs, e); end
    else $display("ok   defer_jump_fwd: %h", obs);
    tick();
    ex_jump_flag_in = 1'b0; ex_jump_addr_in = 32'h0; pc_in = 32'h120;
    settle();
    e = ev(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL defer_accept: got %h expected %h", obs, e); end
    else $display("ok   defer_accept: %h", obs);
    tick();
    ex_jump_flag_in = 1'b1; ex_jump_addr_in = 32'h200;
    settle();
    e = ev(0, 0, 1, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL drain_jump_suppressed: got %h expected %h", obs, e); end
    else $display("ok   drain_jump_suppressed: %h", obs);
    checks++;
    if (epc_out !== 32'h120) begin errors++; $display("FAIL defer_epc_entry: got %h expected %h", epc_out, 32'h120); end
    else $display("ok   defer_epc_entry: %h", epc_out);
    tick();
    ex_jump_flag_in = 1'b0; ex_jump_addr_in = 32'h0;
    settle();
    checks++;
    if (epc_out !== 32'h200) begin errors++; $display("FAIL drain_epc_redirect: got %h expected %h", epc_out, 32'h200); end
    else $display("ok   drain_epc_redirect: %h", epc_out);
    tick();
    settle();
    e = ev(1, 32'h300, 3, 1, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL defer_trap: got %h expected %h", obs, e); end
    else $display("ok   defer_trap: %h", obs);
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_bus_stall();
    int drain_cycles;
    bit acked;
    pc_in = 32'h60; int_req_in = 1'b1; int_addr_in = 32'h400;
    tick();
    drain_cycles = 0;
    acked = 1'b0;
    // Stall for 3 cycles starting at the second drain cycle.
    for (int i = 0; i < 20 && !acked; i++) begin
      bus_hold_req_in = (i >= 1 && i <= 3);
      settle();
      if (int_ack_out === 1'b1) begin
        acked = 1'b1;
        e = ev(1, 32'h400, 3, 1, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_trap: got %h expected %h", obs, e); end
        else $display("ok   stall_trap: %h", obs);
      end else begin
        drain_cycles++;
        e = ev(0, 0, 1, 0, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL stall_drain_%0d: got %h expected %h", i, obs, e); end
        else $display("ok   stall_drain_%0d: %h", i, obs);
      end
      tick();
    end
    checks++;
    if (!acked || drain_cycles != 5) begin
      errors++;
      $display("FAIL stall_delay: got %0d drain cycles (acked=%0d) expected 5", drain_cycles, acked);
    end else $display("ok   stall_delay: %0d drain cycles", drain_cycles);
    clear_inputs();
    tick();
  endtask

  task automatic test_halt();
    dbg_halt_req_in = 1'b1;
    settle();
    e = ev(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL halt_request: got %h expected %h", obs, e); end
    else $display("ok   halt_request: %h", obs);
    tick();
    pc_in = 32'h70; int_req_in = 1'b1; int_addr_in = 32'h500;
    for (int i = 0; i < 3; i++) begin
      ex_jump_flag_in = (i == 1); ex_jump_addr_in = (i == 1) ? 32'h777 : 32'h0;
      dbg_halt_req_in = (i < 2);
      settle();
      e = ev(0, 0, 3, 0, 1); checks++;
      if (obs !== e) begin errors++; $display("FAIL halt_hold_%0d: got %h expected %h", i, obs, e); end
      else $display("ok   halt_hold_%0d: %h", i, obs);
      tick();
    end
    ex_jump_flag_in = 1'b0; ex_jump_addr_in = 32'h0;
    settle();
    e = ev(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL halt_release: got %h expected %h", obs, e); end
    else $display("ok   halt_release: %h", obs);
    tick();
    tick();
    tick();
    settle();
    e = ev(1, 32'h500, 3, 1, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL halt_then_trap: got %h expected %h", obs, e); end
    else $display("ok   halt_then_trap: %h", obs);
    checks++;
    if (epc_out !== 32'h70) begin errors++; $display("FAIL halt_then_epc: got %h expected %h", epc_out, 32'h70); end
    else $display("ok   halt_then_epc: %h", epc_out);
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_in_drain();
    pc_in = 32'h90; int_req_in = 1'b1; int_addr_in = 32'h600;
    tick();
    settle();
    e = ev(0, 0, 1, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_drain_entered: got %h expected %h", obs, e); end
    else $display("ok   rst_drain_entered: %h", obs);
    rst = 1'b1;
    #1;
    e = ev(0, 0, 0, 0, 0); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_drain_gated: got %h expected %h", obs, e); end
    else $display("ok   rst_drain_gated: %h", obs);
    tick();
    rst = 1'b0;
    int_req_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      e = ev(0, 0, 0, 0, 0); checks++;
      if (obs !== e) begin errors++; $display("FAIL rst_drain_run_%0d: got %h expected %h", i, obs, e); end
      else $display("ok   rst_drain_run_%0d: %h", i, obs);
      tick();
    end
    checks++;
    if (epc_out !== 32'h0) begin errors++; $display("FAIL rst_drain_epc: got %h expected %h", epc_out, 32'h0); end
    else $display("ok   rst_drain_epc: %h", epc_out);
  endtask

  initial begin
    rst   = 1'b1;
    pc_in = 32'h0;
    clear_inputs();
    test_reset();
    test_jump();
    test_holds();
    test_int_entry();
    test_deferral();
    test_bus_stall();
    test_halt();
    test_reset_in_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
